// File: rtl/counter_pkg.sv
// Shared types and constants for the counter controller and its datapath.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUN,
    PAUSED,
    DONE
  } state_t;

endpackage

// File: rtl/counter_en.sv
// WIDTH-bit up-counter with synchronous clear (dominant) and count enable.
module counter_en
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + ONE;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/counter_ctrl.sv
// Configurable one-shot / periodic counter: config handshake, run control FSM,
// terminal detection, and registered tick/done flags around a counter_en datapath.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             done,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] limit_reg;
  logic             periodic_reg;
  logic             tick_reg, tick_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] terminal;
  logic             at_terminal;
  logic             cfg_accept;
  logic             cnt_clear;
  logic             cnt_enable;

  assign cfg_ready  = (state_reg == IDLE) || (state_reg == DONE);
  assign busy       = (state_reg == RUN) || (state_reg == PAUSED);
  assign cfg_accept = cfg_valid && cfg_ready;

  // A limit of 0 wraps to an all-ones terminal, i.e. a full 2**WIDTH period.
  assign terminal    = limit_reg - ONE;
  assign at_terminal = (count == terminal);

  always_comb begin
    state_next = state_reg;
    tick_next  = 1'b0;
    done_next  = done_reg;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg_accept) state_next = ARMED;
      end
      ARMED: begin
        if (stop) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end else if (start) begin
          state_next = RUN;
          cnt_clear  = 1'b1;
        end
      end
      RUN: begin
        // Priority: stop, then pause, then terminal reload, then increment.
        if (stop) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end else if (pause) begin
          state_next = PAUSED;
        end else if (at_terminal) begin
          cnt_clear = 1'b1;
          tick_next = 1'b1;
          if (!periodic_reg) begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end else begin
          cnt_enable = 1'b1;
        end
      end
      PAUSED: begin
        if (stop) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end else if (!pause) begin
          state_next = RUN;
        end
      end
      DONE: begin
        // A new config offered alongside start takes precedence over the restart.
        if (cfg_accept) begin
          state_next = ARMED;
          done_next  = 1'b0;
        end else if (start) begin
          state_next = RUN;
          cnt_clear  = 1'b1;
          done_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      tick_reg     <= 1'b0;
      done_reg     <= 1'b0;
      limit_reg    <= '0;
      periodic_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      done_reg  <= done_next;
      if (cfg_accept) begin
        limit_reg    <= cfg_limit;
        periodic_reg <= cfg_periodic;
      end
    end
  end

  counter_en #(
    .WIDTH(WIDTH)
  ) u_counter_en (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .enable(cnt_enable),
    .count (count)
  );

  assign tick = tick_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed scenarios plus randomized run-control traffic, checked against a
// flag-based behavioural model of the counter controller.
module tb_counter_ctrl;

  localparam int W   = 4;
  localparam int MOD = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_limit;
  logic         cfg_periodic;
  logic         start;
  logic         stop;
  logic         pause;
  logic [W-1:0] count;
  logic         tick;
  logic         done;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: plain flags and an integer count.
  bit m_armed, m_run, m_paused, m_done, m_tick, m_per;
  int m_count, m_lim;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_limit   (cfg_limit),
    .cfg_periodic(cfg_periodic),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .count       (count),
    .tick        (tick),
    .done        (done),
    .busy        (busy)
  );

  task automatic clear_inputs();
    reset = 1'b0; cfg_valid = 1'b0; cfg_limit = '0; cfg_periodic = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  // One clock edge: the model consumes the same inputs the DUT saw, then outputs settle.
  task automatic step();
    int  period;
    bit  ready;
    @(posedge clk);
    period = (m_lim == 0) ? MOD : m_lim;
    ready  = !(m_armed || m_run || m_paused);
    m_tick = 1'b0;
    if (reset) begin
      m_armed = 0; m_run = 0; m_paused = 0; m_done = 0;
      m_count = 0; m_lim = 0; m_per = 0;
    end else if (ready && cfg_valid) begin
      m_lim = int'(cfg_limit); m_per = cfg_periodic; m_done = 0; m_armed = 1;
    end else if (stop && (m_armed || m_run || m_paused)) begin
      m_armed = 0; m_run = 0; m_paused = 0; m_count = 0;
    end else if (start && (m_armed || m_done)) begin
      m_armed = 0; m_done = 0; m_run = 1; m_count = 0;
    end else if (m_run) begin
      if (pause) begin
        m_run = 0; m_paused = 1;
      end else if (m_count == period - 1) begin
        m_count = 0; m_tick = 1;
        if (!m_per) begin m_run = 0; m_done = 1; end
      end else begin
        m_count = m_count + 1;
      end
    end else if (m_paused && !pause) begin
      m_paused = 0; m_run = 1;
    end
    #1;
  endtask

  task automatic configure(input int lim, input bit per);
    cfg_valid = 1'b1; cfg_limit = W'(lim); cfg_periodic = per;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_cmp++; if (count !== 4'd0)  begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (tick !== 1'b0)  begin n_bad++; $display("FAIL reset_tick: got %b want 0", tick); end
    $display("test_reset: complete");
  endtask

  task automatic test_one_shot();
    configure(5, 1'b0);
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL oneshot_armed_ready: got %b want 0", cfg_ready); end
    do_start();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (count !== W'(i)) begin n_bad++; $display("FAIL oneshot_count: got %0d want %0d", count, i); end
      n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL oneshot_tick_early: got %b want 0 at %0d", tick, i); end
      step();
    end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL oneshot_wrap_count: got %0d want 0", count); end
    n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL oneshot_tick: got %b want 1", tick); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL oneshot_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL oneshot_busy: got %b want 0", busy); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL oneshot_ready: got %b want 1", cfg_ready); end
    step();
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL oneshot_tick_width: got %b want 0", tick); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL oneshot_done_hold: got %b want 1", done); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL oneshot_count_hold: got %0d want 0", count); end
    $display("test_one_shot: complete");
  endtask

  task automatic test_wrap();
    configure(0, 1'b1);
    do_start();
    for (int k = 0; k <= 3 * MOD; k++) begin
      n_cmp++; if (count !== W'(k % MOD)) begin n_bad++; $display("FAIL wrap_count: got %0d want %0d", count, k % MOD); end
      n_cmp++; if (tick !== ((k % MOD == 0) && (k > 0))) begin n_bad++; $display("FAIL wrap_tick: got %b at k=%0d", tick, k); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL wrap_done: got %b want 0", done); end
      step();
    end
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++; if (count !== 4'd0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL wrap_stop: count=%0d ready=%b busy=%b want 0/1/0", count, cfg_ready, busy);
    end
    $display("test_wrap: complete");
  endtask

  task automatic test_pause();
    configure(10, 1'b0);
    do_start();
    step(); step(); step();
    n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL pause_pre: got %0d want 3", count); end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL pause_hold: got %0d want 3", count); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pause_busy: got %b want 1", busy); end
    end
    pause = 1'b0;
    step();
    n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL pause_release: got %0d want 3", count); end
    for (int v = 4; v <= 6; v++) begin
      step();
      n_cmp++; if (count !== W'(v)) begin n_bad++; $display("FAIL pause_resume: got %0d want %0d", count, v); end
    end
    stop = 1'b1; step(); stop = 1'b0;
    $display("test_pause: complete");
  endtask

  task automatic test_stop_at_terminal();
    configure(6, 1'b0);
    do_start();
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL stopterm_tick_run: got %b want 0", tick); end
    end
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL stopterm_pre: got %0d want 5", count); end
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL stopterm_count: got %0d want 0", count); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL stopterm_tick: got %b want 0", tick); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL stopterm_done: got %b want 0", done); end
    n_cmp++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL stopterm_idle: ready=%b busy=%b want 1/0", cfg_ready, busy);
    end
    step();
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL stopterm_tick_after: got %b want 0", tick); end
    $display("test_stop_at_terminal: complete");
  endtask

  task automatic test_reset_mid_run();
    configure(12, 1'b0);
    do_start();
    repeat (7) step();
    n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL rstrun_pre: got %0d want 7", count); end
    reset = 1'b1; step(); reset = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rstrun_count: got %0d want 0", count); end
    n_cmp++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rstrun_idle: ready=%b busy=%b want 1/0", cfg_ready, busy);
    end
    n_cmp++; if (done !== 1'b0 || tick !== 1'b0) begin
      n_bad++; $display("FAIL rstrun_flags: done=%b tick=%b want 0/0", done, tick);
    end
    do_start();
    step();
    n_cmp++; if (busy !== 1'b0 || count !== 4'd0) begin
      n_bad++; $display("FAIL rstrun_start_ignored: busy=%b count=%0d want 0/0", busy, count);
    end
    configure(3, 1'b1);
    do_start();
    step();
    n_cmp++; if (busy !== 1'b1 || count !== 4'd1) begin
      n_bad++; $display("FAIL rstrun_restart: busy=%b count=%0d want 1/1", busy, count);
    end
    stop = 1'b1; step(); stop = 1'b0;
    $display("test_reset_mid_run: complete");
  endtask

  task automatic test_random();
    int bad_before;
    bad_before = n_bad;
    for (int c = 0; c < 1500; c++) begin
      reset        = ($urandom_range(0, 99) == 0);
      cfg_valid    = ($urandom_range(0, 3) == 0);
      cfg_limit    = W'($urandom_range(0, MOD - 1));
      cfg_periodic = $urandom_range(0, 1) == 1;
      start        = ($urandom_range(0, 5) == 0);
      stop         = ($urandom_range(0, 24) == 0);
      pause        = ($urandom_range(0, 7) == 0);
      step();
      n_cmp++;
      if (count !== W'(m_count) || tick !== m_tick || done !== m_done ||
          busy !== (m_run || m_paused) || cfg_ready !== !(m_armed || m_run || m_paused)) begin
        n_bad++;
        $display("FAIL random_cycle %0d: got cnt=%0d tick=%b done=%b busy=%b rdy=%b want cnt=%0d tick=%b done=%b busy=%b rdy=%b",
                 c, count, tick, done, busy, cfg_ready, m_count, m_tick, m_done,
                 m_run || m_paused, !(m_armed || m_run || m_paused));
      end
    end
    clear_inputs();
    $display("test_random: 1500 cycles, %0d new errors", n_bad - bad_before);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_one_shot();
    test_wrap();
    test_pause();
    test_stop_at_terminal();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the count width in bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port cfg_valid, input, 1 bit, configuration offer.
REQ-005 SHALL have port cfg_ready, output, 1 bit, configuration accept.
REQ-006 SHALL have port cfg_limit, input, WIDTH bits, period length in cycles; 0 means 2**WIDTH.
REQ-007 SHALL have port cfg_periodic, input, 1 bit: 1 for periodic mode, 0 for one-shot mode.
REQ-008 SHALL have ports start, stop and pause, each input, 1 bit, run control.
REQ-009 SHALL have port count, output, WIDTH bits, current count.
REQ-010 SHALL have port tick, output, 1 bit, one-cycle terminal pulse.
REQ-011 SHALL have port done, output, 1 bit, one-shot complete level.
REQ-012 SHALL have port busy, output, 1 bit, high in RUN or PAUSED.

Function
REQ-013 SHALL implement FSM states IDLE, ARMED, RUN, PAUSED and DONE.
REQ-014 SHALL drive cfg_ready = 1 only in IDLE or DONE.
REQ-015 SHALL, on cfg_valid && cfg_ready, latch cfg_limit and cfg_periodic, clear done and enter ARMED.
REQ-016 SHALL define the terminal value as (cfg_limit - 1) mod 2**WIDTH, so limit 0 gives terminal 2**WIDTH-1.
REQ-017 SHALL, on start in ARMED or DONE, enter RUN, set count to 0 and clear done; start in IDLE, RUN or PAUSED is ignored.
REQ-018 SHALL, in RUN, increment count by 1 each cycle with modulo-2**WIDTH arithmetic.
REQ-019 SHALL, in RUN with count == terminal, load count to 0 on that edge and assert tick for exactly the following cycle.
REQ-020 SHALL, at terminal in periodic mode, remain in RUN.
REQ-021 SHALL, at terminal in one-shot mode, enter DONE with done = 1 held until the next accepted config or start.
REQ-022 SHALL, on pause in RUN, enter PAUSED and hold count; while PAUSED, pause = 0 returns to RUN with counting resuming on the next edge.
REQ-023 SHALL, on stop in ARMED, RUN or PAUSED, enter IDLE with count 0 and no tick.
REQ-024 SHALL apply priority stop > pause > terminal > increment when these coincide.
REQ-025 SHALL ignore cfg_valid while cfg_ready = 0 and leave the latched config unchanged.
REQ-026 SHALL register count, tick and done; busy and cfg_ready are decoded from state only.

Reset
REQ-027 SHALL, on reset, set state to IDLE, count 0, tick 0, done 0, latched limit 0 and periodic 0, giving cfg_ready = 1 and busy = 0.
REQ-028 SHALL give reset priority over all other inputs, including mid-run, with no tick on the reset edge.

Structure
REQ-029 SHALL place the state enum type and the default WIDTH constant in the shared package counter_pkg.
REQ-030 SHALL instantiate one sub-module, counter_en, a WIDTH-bit counter with clear and enable inputs and a synchronous active-high reset.
REQ-031 SHALL keep all FSM, handshake and terminal compare logic in counter_ctrl.

Verification
REQ-032 SHALL verify reset: hold reset for 2 cycles -> count = 0, cfg_ready = 1, busy = 0, done = 0, tick = 0.
REQ-033 SHALL verify one-shot: cfg limit = 5, periodic = 0, then start -> count 0,1,2,3,4,0; tick high 1 cycle; done = 1; busy = 0; cfg_ready = 1.
REQ-034 SHALL verify wrap: cfg limit = 0, periodic = 1, then start -> count 0..15 then 0 repeatedly; tick every 16 cycles across 3 periods; done stays 0.
REQ-035 SHALL verify pause: limit = 10, pause asserted at count = 3 for 4 cycles -> count holds 3, busy = 1; after release -> 4, 5, ...
REQ-036 SHALL verify stop at terminal: limit = 6, stop asserted while count = 5 -> IDLE, count = 0, tick never asserted, done = 0.
REQ-037 SHALL verify reset mid-run: reset at count = 7 with limit = 12 -> next cycle count = 0, IDLE, done = 0; start then ignored until a new config is accepted.
